// File: rtl/slot_spin_sequencer.sv
// slot_spin_sequencer: turns a start-key press into one slot round.
// The round is a debit pulse, three reels spun and then stopped in staggered
// order, and a done/win result pulse.
// Optional build macro SLOT_DEBOUNCE_EN adds a DB_CYCLES-long debounce on the
// synchronised key before the press edge is taken.
module slot_spin_sequencer #(
  parameter int SYM_W      = 2,
  parameter int STEP_DIV   = 4,
  parameter int SPIN_TICKS = 8,
  parameter int STAGGER    = 2
`ifdef SLOT_DEBOUNCE_EN
  , parameter int DB_CYCLES = 16
`endif
) (
  input  logic               clk,
  input  logic               Clear_b,
  input  logic               start_n,
  input  logic               credit_ok,
  output logic               spin_req,
  output logic               busy,
  output logic [3*SYM_W-1:0] reels,
  output logic               done,
  output logic               win
);

  localparam int PW = $clog2(STEP_DIV);
  localparam int TW = $clog2(SPIN_TICKS + STAGGER + 1);
  localparam logic [PW-1:0]    PS_LAST   = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0]    PS_ONE    = PW'(1);
  localparam logic [TW-1:0]    SPIN_LAST = TW'(SPIN_TICKS - 1);
  localparam logic [TW-1:0]    STAG_LAST = TW'(STAGGER - 1);
  localparam logic [TW-1:0]    T_ONE     = TW'(1);
  localparam logic [SYM_W-1:0] R_ONE     = SYM_W'(1);

  typedef enum logic [2:0] {IDLE, SPIN, STOP_A, STOP_B, EVAL} state_t;

  state_t           state_q;
  logic             sync1_q, sync2_q;
  logic             key_lvl;
  logic             key_prev_q, press_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic [TW-1:0]    tick_cnt_q;
  logic [SYM_W-1:0] a_q, b_q, c_q, a_d, b_d, c_d;
  logic             spin_req_q, busy_q, done_q, win_q;
  logic             tick;

  // Two-flop synchroniser for the asynchronous start key
  always_ff @(posedge clk or negedge Clear_b) begin
    if (!Clear_b) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= start_n;
      sync2_q <= sync1_q;
    end
  end

`ifdef SLOT_DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES + 1);
  logic [DW-1:0] db_cnt_q;
  logic          db_lvl_q;

  // Debounced level flips only after DB_CYCLES consecutive opposite samples
  always_ff @(posedge clk or negedge Clear_b) begin
    if (!Clear_b) begin
      db_cnt_q <= '0;
      db_lvl_q <= 1'b1;
    end else if (sync2_q == db_lvl_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DW'(DB_CYCLES - 1)) begin
      db_cnt_q <= '0;
      db_lvl_q <= sync2_q;
    end else begin
      db_cnt_q <= db_cnt_q + DW'(1);
    end
  end

  assign key_lvl = db_lvl_q;
`else
  assign key_lvl = sync2_q;
`endif

  // Registered falling-edge detect: one pulse per press, holding never re-fires
  always_ff @(posedge clk or negedge Clear_b) begin
    if (!Clear_b) begin
      key_prev_q <= 1'b1;
      press_q    <= 1'b0;
    end else begin
      key_prev_q <= key_lvl;
      press_q    <= key_prev_q & ~key_lvl;
    end
  end

  assign presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PS_ONE;
  assign tick    = (state_q inside {SPIN, STOP_A, STOP_B}) && (presc_q == PS_LAST);

  // Reel next values: a reel advances on a tick only while it is still running
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    if (tick) begin
      if (state_q == SPIN)                       a_d = a_q + R_ONE;
      if (state_q inside {SPIN, STOP_A})         b_d = b_q + R_ONE;
      if (state_q inside {SPIN, STOP_A, STOP_B}) c_d = c_q + R_ONE;
    end
  end

  // Round FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clk or negedge Clear_b) begin
    if (!Clear_b) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      spin_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      spin_req_q <= 1'b0;
      done_q     <= 1'b0;
      win_q      <= 1'b0;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      unique case (state_q)
        IDLE: begin
          presc_q    <= '0;
          tick_cnt_q <= '0;
          if (press_q && credit_ok) begin
            state_q    <= SPIN;
            spin_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        SPIN: begin
          presc_q <= presc_d;
          if (tick) begin
            if (tick_cnt_q == SPIN_LAST) begin
              state_q    <= STOP_A;
              tick_cnt_q <= '0;
            end else begin
              tick_cnt_q <= tick_cnt_q + T_ONE;
            end
          end
        end
        STOP_A: begin
          presc_q <= presc_d;
          if (tick) begin
            if (tick_cnt_q == STAG_LAST) begin
              state_q    <= STOP_B;
              tick_cnt_q <= '0;
            end else begin
              tick_cnt_q <= tick_cnt_q + T_ONE;
            end
          end
        end
        STOP_B: begin
          presc_q <= presc_d;
          if (tick) begin
            if (tick_cnt_q == STAG_LAST) begin
              state_q    <= EVAL;
              tick_cnt_q <= '0;
              done_q     <= 1'b1;
              win_q      <= (a_d == b_d) && (b_d == c_d);
            end else begin
              tick_cnt_q <= tick_cnt_q + T_ONE;
            end
          end
        end
        EVAL: begin
          // Clear the prescaler here so a round started right after is aligned
          state_q <= IDLE;
          busy_q  <= 1'b0;
          presc_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign spin_req = spin_req_q;
  assign busy     = busy_q;
  assign reels    = {a_q, b_q, c_q};
  assign done     = done_q;
  assign win      = win_q;

endmodule

// File: tb/tb_slot_spin_sequencer.sv
// Bench for slot_spin_sequencer: table of key/credit scenarios, timing corner
// sequences and a randomized run, all against a time-based round model.
module tb_slot_spin_sequencer;

  localparam int SW    = 2;
  localparam int D     = 4;
  localparam int S     = 8;
  localparam int G     = 2;
  localparam int M     = 1 << SW;
  localparam int ROUND = (S + 2 * G) * D;
  localparam int BIG   = 100000;

  logic          clk = 1'b0;
  logic          Clear_b = 1'b0;
  logic          start_n = 1'b1;
  logic          credit_ok = 1'b0;
  logic          spin_req, busy, done, win;
  logic [3*SW-1:0] reels;

  slot_spin_sequencer #(.SYM_W(SW), .STEP_DIV(D), .SPIN_TICKS(S), .STAGGER(G)) dut (
    .clk(clk), .Clear_b(Clear_b), .start_n(start_n), .credit_ok(credit_ok),
    .spin_req(spin_req), .busy(busy), .reels(reels), .done(done), .win(win)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Model: key samples per edge since reset, start edge of the latest round,
  // and the reel values that round started from.
  bit hist[$];
  int e = 0;
  int last_t0 = -BIG;
  bit have_round = 0;
  int a0 = 0, b0 = 0, c0 = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
  endtask

  function automatic bit hv(input int i);
    if (i < 0) return 1'b1;
    return hist[i];
  endfunction

  function automatic int rv(input int base, input int lim, input int t);
    return (base + ((t < lim) ? t : lim)) % M;
  endfunction

  // One clock: drive inputs, take the edge, advance the model, compare outputs
  task automatic step(input logic sn, input logic cok);
    int k, t, ea, eb, ec, fa, fb, fc;
    bit press, x_spin, x_busy, x_done, x_win;
    start_n   = sn;
    credit_ok = cok;
    @(posedge clk);
    hist.push_back(sn);
    press = (hv(e - 3) == 1'b0) && (hv(e - 4) == 1'b1);
    if (press && cok && (e >= last_t0 + ROUND + 2)) begin
      if (have_round) begin
        a0 = rv(a0, S, BIG);
        b0 = rv(b0, S + G, BIG);
        c0 = rv(c0, S + 2 * G, BIG);
      end
      have_round = 1;
      last_t0    = e;
    end
    #1;
    k = e - last_t0;
    x_spin = have_round && (k == 0);
    x_busy = have_round && (k >= 0) && (k <= ROUND);
    x_done = have_round && (k == ROUND);
    t  = have_round ? (((k < ROUND) ? k : ROUND) / D) : 0;
    ea = rv(a0, S, t);
    eb = rv(b0, S + G, t);
    ec = rv(c0, S + 2 * G, t);
    fa = rv(a0, S, BIG);
    fb = rv(b0, S + G, BIG);
    fc = rv(c0, S + 2 * G, BIG);
    x_win = x_done && (fa == fb) && (fb == fc);
    chk("spin_req", int'(spin_req), int'(x_spin));
    chk("busy",     int'(busy),     int'(x_busy));
    chk("done",     int'(done),     int'(x_done));
    chk("win",      int'(win),      int'(x_win));
    chk("reels",    int'(reels),    ea * M * M + eb * M + ec);
    if (x_done) $display("round done at edge %0d: reels=%h win=%0b", e, reels, win);
    e++;
  endtask

  task automatic do_reset();
    #2 Clear_b = 1'b0;
    #1;
    chk("rst_reels", int'(reels), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_spin",  int'(spin_req), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_win",   int'(win), 0);
    @(posedge clk);
    @(posedge clk);
    #2 Clear_b = 1'b1;
    hist.delete();
    e = 0;
    last_t0 = -BIG;
    have_round = 0;
    a0 = 0; b0 = 0; c0 = 0;
  endtask

  typedef struct {
    string      name;
    logic       cok;
    int         low;
    bit         jitter;
    int         exp_spins;
    int         exp_dones;
    logic [5:0] exp_reels;
    bit         exp_win;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int spins, dones, wseen, cnt;
    logic sn, cok;
    int run;

    vecs[0] = '{"first_round",  1'b1, 4,  1'b0, 1, 1, 6'b00_10_00, 1'b0};
    vecs[1] = '{"second_win",   1'b1, 4,  1'b0, 1, 1, 6'b00_00_00, 1'b1};
    vecs[2] = '{"no_credit",    1'b0, 4,  1'b0, 0, 0, 6'b00_00_00, 1'b0};
    vecs[3] = '{"hold_key",     1'b1, 70, 1'b0, 1, 1, 6'b00_10_00, 1'b0};
    vecs[4] = '{"extra_presses",1'b1, 60, 1'b1, 1, 1, 6'b00_00_00, 1'b1};
    vecs[5] = '{"one_cyc_press",1'b1, 1,  1'b0, 1, 1, 6'b00_10_00, 1'b0};

    do_reset();

    // Table-driven scenarios, each 70 active cycles plus 5 idle-high cycles
    for (int v = 0; v < 6; v++) begin
      spins = 0; dones = 0; wseen = 0;
      for (int c = 0; c < 75; c++) begin
        sn = (c < vecs[v].low) ? 1'b0 : 1'b1;
        if (vecs[v].jitter && c >= 10 && c < 40) sn = c[1];
        if (c >= 70) sn = 1'b1;
        step(sn, vecs[v].cok);
        if (spin_req) spins++;
        if (done) begin dones++; wseen = int'(win); end
      end
      chk({vecs[v].name, "_spins"}, spins, vecs[v].exp_spins);
      chk({vecs[v].name, "_dones"}, dones, vecs[v].exp_dones);
      chk({vecs[v].name, "_reels"}, int'(reels), int'(vecs[v].exp_reels));
      chk({vecs[v].name, "_win"},   wseen, int'(vecs[v].exp_win));
      $display("vec %0d %s: spins=%0d dones=%0d reels=%h win=%0d",
               v, vecs[v].name, spins, dones, reels, wseen);
    end

    // Press landing in the EVAL->IDLE cycle is dropped
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1);
    for (int g = 0; g < 200 && e < last_t0 + 46; g++) step(1'b1, 1'b1);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin step(1'b0, 1'b1); if (spin_req) cnt++; end
    for (int c = 0; c < 60; c++) begin step(1'b1, 1'b1); if (spin_req) cnt++; end
    chk("eval_press_ignored", cnt, 0);
    $display("seq eval-boundary press: extra spins=%0d", cnt);

    // Press landing one cycle later, first IDLE cycle, is accepted
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1);
    for (int g = 0; g < 200 && e < last_t0 + 47; g++) step(1'b1, 1'b1);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin step(1'b0, 1'b1); if (spin_req) cnt++; end
    for (int c = 0; c < 60; c++) begin step(1'b1, 1'b1); if (spin_req) cnt++; end
    chk("idle_press_taken", cnt, 1);
    $display("seq first-idle press: spins=%0d", cnt);

    // Mid-round reset at T0+20 aborts with no done pulse
    for (int c = 0; c < 4; c++) step(1'b0, 1'b1);
    for (int g = 0; g < 200 && e < last_t0 + 21; g++) step(1'b1, 1'b1);
    do_reset();
    cnt = 0;
    for (int c = 0; c < 60; c++) begin step(1'b1, 1'b1); if (done) cnt++; end
    chk("abort_no_done", cnt, 0);
    $display("seq mid-round reset: dones after=%0d", cnt);

    // Randomized key/credit activity
    sn = 1'b1; cok = 1'b1; run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        sn  = ~sn;
        run = $urandom_range(1, 70);
      end
      run--;
      if ($urandom_range(0, 29) == 0) cok = ~cok;
      step(sn, cok);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
